// File: rtl/ws2812_serializer.sv
// ws2812_serializer: pixel words to the WS2812 single-wire bitstream.
// Define WS_RGBW_EN for 32-bit GRBW pixels (SK6812); default is 24-bit GRB.
module ws2812_serializer #(
   parameter int SYSTEM_CLOCK = 50000000,
   parameter int T0H_NS       = 400,
   parameter int T1H_NS       = 800,
   parameter int BIT_NS       = 1250,
   parameter int RESET_US     = 80,
`ifdef WS_RGBW_EN
   localparam int PW          = 32
`else
   localparam int PW          = 24
`endif
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic [PW-1:0] pix_data_i,
   input  logic          pix_valid_i,
   input  logic          pix_last_i,
   output logic          pix_ready_o,
   output logic          do_o,
   output logic          bsy_o,
   output logic          underrun_o
);

   localparam int MHZ     = SYSTEM_CLOCK / 1000000;
   localparam int T0H_CYC = MHZ * T0H_NS / 1000;
   localparam int T1H_CYC = MHZ * T1H_NS / 1000;
   localparam int BIT_CYC = MHZ * BIT_NS / 1000;
   localparam int RST_CYC = MHZ * RESET_US;
   localparam int CW      = $clog2(BIT_CYC);
   localparam int LW      = $clog2(RST_CYC + 1);
   localparam int IW      = $clog2(PW);

   localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] C_T0H  = CW'(T0H_CYC);
   localparam logic [CW-1:0] C_T1H  = CW'(T1H_CYC);
   localparam logic [LW-1:0] L_LAST = LW'(RST_CYC - 1);
   localparam logic [IW-1:0] I_TOP  = IW'(PW - 1);

   generate
      if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
         $error("ws2812_serializer: need 0 < T0H < T1H < BIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_BIT,
      S_LATCH
   } state_t;

   state_t        state;
   logic [PW-1:0] shreg;
   logic          last_q;
   logic [CW-1:0] cyc;
   logic [IW-1:0] idx;
   logic [LW-1:0] lcnt;

   logic          bit_end;
   logic          pix_end;
   logic [CW-1:0] cyc_nxt;
   logic [CW-1:0] hi_cyc;

   assign bit_end = (state == S_BIT) && (cyc == C_LAST);
   assign pix_end = bit_end && (idx == '0);
   assign cyc_nxt = cyc + 1'b1;
   assign hi_cyc  = shreg[PW-1] ? C_T1H : C_T0H;

   // Ready in the final low cycle of a non-last pixel keeps the bit period seamless.
   assign pix_ready_o = !reset_i &&
                        ((state == S_IDLE) || (pix_end && !last_q));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= S_IDLE;
         shreg      <= '0;
         last_q     <= 1'b0;
         cyc        <= '0;
         idx        <= '0;
         lcnt       <= '0;
         do_o       <= 1'b0;
         bsy_o      <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         underrun_o <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pix_valid_i) begin
                  shreg  <= pix_data_i;
                  last_q <= pix_last_i;
                  cyc    <= '0;
                  idx    <= I_TOP;
                  do_o   <= 1'b1;
                  bsy_o  <= 1'b1;
                  state  <= S_BIT;
               end
            end
            S_BIT: begin
               if (!bit_end) begin
                  cyc  <= cyc_nxt;
                  do_o <= (cyc_nxt < hi_cyc);
               end else if (idx != '0) begin
                  shreg <= shreg << 1;
                  idx   <= idx - 1'b1;
                  cyc   <= '0;
                  do_o  <= 1'b1;
               end else if (last_q) begin
                  lcnt  <= '0;
                  do_o  <= 1'b0;
                  state <= S_LATCH;
               end else if (pix_valid_i) begin
                  shreg  <= pix_data_i;
                  last_q <= pix_last_i;
                  cyc    <= '0;
                  idx    <= I_TOP;
                  do_o   <= 1'b1;
               end else begin
                  do_o       <= 1'b0;
                  bsy_o      <= 1'b0;
                  underrun_o <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_LATCH: begin
               if (lcnt == L_LAST) begin
                  bsy_o <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            default: begin
               do_o  <= 1'b0;
               bsy_o <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_serializer.sv
// tb_ws2812_serializer: random pixel frames against a waveform model
// built from the bit timing rules of the WS2812 protocol.
module tb_ws2812_serializer;

   localparam int CLK_HZ  = 50000000;
   localparam int MHZ     = CLK_HZ / 1000000;
   localparam int T0H_CYC = MHZ * 400 / 1000;
   localparam int T1H_CYC = MHZ * 800 / 1000;
   localparam int BIT_CYC = MHZ * 1250 / 1000;
   localparam int RST_CYC = MHZ * 80;
`ifdef WS_RGBW_EN
   localparam int PW = 32;
`else
   localparam int PW = 24;
`endif

   logic          clk;
   logic          rst;
   logic [PW-1:0] data;
   logic          valid;
   logic          last;
   logic          ready;
   logic          dout;
   logic          bsy;
   logic          under;

   int vecs;
   int errs;

   ws2812_serializer dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .pix_data_i  (data),
      .pix_valid_i (valid),
      .pix_last_i  (last),
      .pix_ready_o (ready),
      .do_o        (dout),
      .bsy_o       (bsy),
      .underrun_o  (under)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Sends px back to back; end_last marks the final pixel as frame end,
   // hold_next keeps valid asserted afterwards (through the latch gap).
   task automatic frame(input logic [PW-1:0] px[$], input bit end_last,
                        input bit hold_next, output int waited);
      int          n;
      int          hi;
      int          bsy_lo;
      int          ur_hi;
      int          lat;
      int          lat_hi;
      bit          lf;
      logic [63:0] obs;
      logic [63:0] expv;
      n      = px.size();
      data   = px[0];
      last   = (n == 1) && end_last;
      valid  = 1'b1;
      waited = 0;
      while (!ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!ready) begin
         check("accept_timeout", 64'(0), 64'(1));
         valid = 1'b0;
         return;
      end
      @(negedge clk);
      bsy_lo = 0;
      ur_hi  = 0;
      for (int k = 0; k < n; k++) begin
         lf = (k == n - 1) && end_last;
         for (int b = PW - 1; b >= 0; b--) begin
            hi   = px[k][b] ? T1H_CYC : T0H_CYC;
            obs  = '0;
            expv = '0;
            for (int c = 0; c < BIT_CYC; c++) begin
               if (c == 0 && b == PW - 1) begin
                  if (k + 1 < n) begin
                     data  = px[k+1];
                     last  = (k + 1 == n - 1) && end_last;
                     valid = 1'b1;
                  end else begin
                     data  = PW'($urandom);
                     last  = 1'b0;
                     valid = hold_next;
                  end
               end
               obs[c]  = dout;
               expv[c] = (c < hi);
               if (!bsy) bsy_lo++;
               if (under) ur_hi++;
               if (c == BIT_CYC - 1)
                  check("ready_end", 64'(ready), 64'((b == 0) && !lf));
               @(negedge clk);
            end
            check("bit_wave", obs, expv);
         end
      end
      check("bsy_low_in_frame", 64'(bsy_lo), 64'(0));
      check("underrun_in_frame", 64'(ur_hi), 64'(0));
      if (end_last) begin
         lat    = 0;
         lat_hi = 0;
         bsy_lo = 0;
         while (!ready && lat < RST_CYC + 50) begin
            if (dout) lat_hi++;
            if (!bsy) bsy_lo++;
            lat++;
            @(negedge clk);
         end
         check("latch_len", 64'(lat), 64'(RST_CYC));
         check("latch_do", 64'(lat_hi), 64'(0));
         check("latch_bsy", 64'(bsy_lo), 64'(0));
         check("idle_bsy", 64'(bsy), 64'(0));
         check("idle_do", 64'(dout), 64'(0));
      end else begin
         check("underrun_pulse", 64'(under), 64'(1));
         check("idle_bsy", 64'(bsy), 64'(0));
         check("idle_do", 64'(dout), 64'(0));
         check("idle_ready", 64'(ready), 64'(1));
         @(negedge clk);
         check("underrun_clear", 64'(under), 64'(0));
         check("idle_do2", 64'(dout), 64'(0));
         check("idle_bsy2", 64'(bsy), 64'(0));
      end
   endtask

   logic [PW-1:0] q[$];
   int            w;

   initial begin
      vecs  = 0;
      errs  = 0;
      rst   = 1'b1;
      valid = 1'b0;
      last  = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      check("rst_do", 64'(dout), 64'(0));
      check("rst_bsy", 64'(bsy), 64'(0));
      check("rst_under", 64'(under), 64'(0));
      check("rst_ready", 64'(ready), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(ready), 64'(1));

      q.delete();
`ifdef WS_RGBW_EN
      q.push_back(32'h0000_00FF);
`else
      q.push_back(24'hA5_00_00);
`endif
      frame(q, 1'b1, 1'b0, w);
      check("accept_wait", 64'(w), 64'(0));

      q.delete();
      q.push_back(PW'($urandom));
      q.push_back(PW'($urandom));
      frame(q, 1'b1, 1'b0, w);
      check("accept_wait", 64'(w), 64'(0));

      q.delete();
      q.push_back(PW'($urandom));
      frame(q, 1'b0, 1'b0, w);
      check("accept_wait", 64'(w), 64'(0));

      q.delete();
      q.push_back(PW'($urandom));
      frame(q, 1'b1, 1'b1, w);
      check("accept_wait", 64'(w), 64'(0));
      q.delete();
      q.push_back(PW'($urandom));
      frame(q, 1'b1, 1'b0, w);
      check("hold_accept_wait", 64'(w), 64'(0));

      repeat (4) begin
         int n;
         bit el;
         bit hn;
         n  = $urandom_range(1, 3);
         el = ($urandom_range(0, 1) != 0);
         hn = el && ($urandom_range(0, 1) != 0);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(PW'($urandom));
         frame(q, el, hn, w);
         check("accept_wait", 64'(w), 64'(0));
      end

      data  = PW'($urandom);
      last  = 1'b1;
      valid = 1'b1;
      w     = 0;
      while (!ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("rst_test_accept", 64'(ready), 64'(1));
      @(negedge clk);
      valid = 1'b0;
      repeat (10 * BIT_CYC + 5) @(negedge clk);
      check("pre_rst_do", 64'(dout), 64'(1));
      rst = 1'b1;
      #1;
      check("async_rst_do", 64'(dout), 64'(0));
      check("async_rst_bsy", 64'(bsy), 64'(0));
      check("async_rst_ready", 64'(ready), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", 64'(ready), 64'(1));
      check("rel_do", 64'(dout), 64'(0));
      check("rel_bsy", 64'(bsy), 64'(0));
      q.delete();
      q.push_back(PW'($urandom));
      frame(q, 1'b1, 1'b0, w);
      check("accept_wait", 64'(w), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ws2812_serializer.md
# ws2812_serializer

Converts a stream of pixel words into the single-wire WS2812/NeoPixel bitstream on `do_o`. It sits directly downstream of the SPI receive and pixel buffer logic inside each `spi_to_neopix` strip controller. It takes one pixel at a time over a valid/ready handshake, shifts the pixel out MSB-first with per-bit high/low timing derived from `SYSTEM_CLOCK`, and drives the latch (reset) gap after the last pixel of a frame. `bsy_o` feeds the strip-busy LED stretcher.

## Interface

- `SYSTEM_CLOCK`, 50000000, clock frequency in Hz
- `T0H_NS`, 400, high time of a 0 bit in ns
- `T1H_NS`, 800, high time of a 1 bit in ns
- `BIT_NS`, 1250, total bit period in ns
- `RESET_US`, 80, latch gap after the frame in µs
- `clk_i  input  1  system clock; all logic on rising edge`
- `reset_i  input  1  asynchronous, active-high reset`
- `pix_data_i  input  PW  pixel word, GRB order, MSB first; PW=24 (32 with WS_RGBW_EN, GRBW)`
- `pix_valid_i  input  1  pix_data_i/pix_last_i valid`
- `pix_last_i  input  1  pixel is the final one of the frame`
- `pix_ready_o  output  1  serializer accepts a pixel this cycle`
- `do_o  output  1  registered strip data output`
- `bsy_o  output  1  high in any state except IDLE`
- `underrun_o  output  1  one-cycle pulse when a non-last pixel ends with no successor available`

## Operation

- Cycle constants are integer arithmetic: `CYC(ns) = (SYSTEM_CLOCK/1000000)*ns/1000` and `RST = (SYSTEM_CLOCK/1000000)*RESET_US`.
- At 50 MHz: T0H=20, T1H=40, BIT=62, RST=4000 cycles.
- Elaboration requires `0 < T0H < T1H < BIT`.
- The bit counter is `$clog2(BIT)` wide and the latch counter `$clog2(RST+1)` wide.
- States:
  - IDLE: `do_o`=0 and `pix_ready_o`=1. On accept (valid&&ready), load the shift register and the last flag, then go to BIT.
  - BIT: drive `do_o`=1 for T0H or T1H cycles, chosen by the current MSB, then `do_o`=0 for the rest of the BIT period.
  - After bit 0 of a pixel (PW bits total):
    - last flag set: go to LATCH.
    - pixel accepted in the final cycle: stay in BIT with the new word, with no gap.
    - otherwise: go to IDLE and pulse `underrun_o`.
  - LATCH: `do_o`=0 for RST cycles, `pix_ready_o`=0, then go to IDLE.
- `pix_ready_o` is combinational: high in IDLE, high in the final cycle of the last bit of a non-last pixel, low everywhere else.
- Valid held during LATCH is not accepted. It is taken on the first IDLE cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately and the state returns to IDLE. The partial frame is discarded with no latch gap.
- Reset values: `do_o`=0, `bsy_o`=0, `underrun_o`=0, `pix_ready_o`=0 while `reset_i` is high.

## Timing

- Accept in cycle N: `do_o` rises at N+1 (register delay).
- Each bit spans exactly BIT cycles. `do_o` is high for exactly T0H or T1H of those cycles.
- Back-to-back pixels: the first bit of the next pixel starts on the cycle after the final low cycle of the previous pixel. The period stays continuous at BIT.
- Last pixel: the LATCH cycles are counted from the cycle after its final low cycle. IDLE, with ready=1, follows after RST cycles.
- `bsy_o` rises on the cycle after accept and falls on the first IDLE cycle.
- `underrun_o` is asserted in the first IDLE cycle after the underrun.

## Configuration

- `WS_RGBW_EN` defined: PW=32 (SK6812 GRBW). 32 bits are shifted per pixel and the end-of-pixel decision happens after 32 bits.
- `WS_RGBW_EN` undefined: PW=24 (GRB). The upper data bits do not exist.
- Timing, handshake and states are identical in both builds.

## Test plan

- Single pixel `24'hA5_00_00` with last=1, defaults → `do_o` shows high times 40,20,40,20,20,40,20,40 for the first 8 bits, then 16 bits of 20-high each at 62-cycle period. Then 4000 low cycles, then ready=1.
- Two pixels presented continuously, the first with last=0 → second accepted exactly in the final cycle of bit 0 of the first. 48 contiguous bit periods, no `underrun_o`.
- Pixel with last=0 and valid dropped afterward → `underrun_o` pulses once on the first IDLE cycle. `do_o` stays 0 and `bsy_o`=0.
- `pix_valid_i` held high through LATCH → `pix_ready_o`=0 for all 4000 cycles. Accept occurs on the first IDLE cycle.
- `reset_i` pulsed during bit 10 of a pixel → `do_o`=0 and `bsy_o`=0 asynchronously. After release, ready=1 and a new pixel serializes correctly.
- With `WS_RGBW_EN`, pixel `32'h0000_00FF` last=1 → 24 zero bits (20-high), then 8 one bits (40-high), then LATCH.
